// File: rtl/alu1_pkg.sv
// Shared encodings for the ALU1 string-instruction sequencer: FSM states,
// instruction/prefix/size codes and the element-size to pointer-step mapping.
package alu1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHK    = 3'd1,
        ST_RD_SRC = 3'd2,
        ST_RD_DST = 3'd3,
        ST_WR_DST = 3'd4,
        ST_UPD    = 3'd5,
        ST_FIN    = 3'd6
    } state_e;

    localparam logic       OP_MOVS  = 1'b0;
    localparam logic       OP_CMPS  = 1'b1;

    localparam logic [1:0] REP_NONE = 2'b00;
    localparam logic [1:0] REP_E    = 2'b01;
    localparam logic [1:0] REP_NE   = 2'b10;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_WORD  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;

    function automatic logic [31:0] size_step(input logic [1:0] sz);
        logic [31:0] step;
        case (sz)
            SZ_WORD:  step = 32'd2;
            SZ_DWORD: step = 32'd4;
            default:  step = 32'd1;
        endcase
        return step;
    endfunction

    // The reserved 2'b11 codes collapse onto the plain (non-REP / byte) meaning.
    function automatic logic [1:0] norm_rep(input logic [1:0] rep);
        return (rep == 2'b11) ? REP_NONE : rep;
    endfunction

    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_BYTE : sz;
    endfunction

endpackage

// File: rtl/alu1_str_ptr_upd.sv
// Combinational ESI/EDI/ECX stepping for one string-instruction iteration.
// Pointers wrap modulo 2^32; the count saturates at zero.
module alu1_str_ptr_upd
    import alu1_pkg::*;
(
    input  logic [31:0] esi_i,
    input  logic [31:0] edi_i,
    input  logic [31:0] ecx_i,
    input  logic        df_i,
    input  logic [1:0]  op_size_i,
    input  logic        cnt_en_i,
    output logic [31:0] esi_o,
    output logic [31:0] edi_o,
    output logic [31:0] ecx_o
);

    logic [31:0] step_s;

    // Next pointer and count values
    always_comb begin
        step_s = size_step(op_size_i);
        if (df_i) begin
            esi_o = esi_i - step_s;
            edi_o = edi_i - step_s;
        end else begin
            esi_o = esi_i + step_s;
            edi_o = edi_i + step_s;
        end
        if (cnt_en_i && (ecx_i != 32'd0)) begin
            ecx_o = ecx_i - 32'd1;
        end else begin
            ecx_o = ecx_i;
        end
    end

endmodule

// File: rtl/alu1_str_seq.sv
// MOVS/CMPS string-instruction sequencer with REP/REPE/REPNE prefixes,
// handshaked memory requests, stall freezing and registered outputs.
module alu1_str_seq
    import alu1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        str_op,
    input  logic [1:0]  rep_mode,
    input  logic [1:0]  op_size,
    input  logic        df_val,
    input  logic [31:0] ecx_in,
    input  logic [31:0] esi_in,
    input  logic [31:0] edi_in,
    input  logic        mem_rd_ack,
    input  logic        mem_wr_ack,
    input  logic        cmps_zf,
    input  logic        stall,
    output logic        busy,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_addr,
    output logic        latch_en,
    output logic        ld_flags,
    output logic [31:0] ecx_out,
    output logic [31:0] esi_out,
    output logic [31:0] edi_out,
    output logic        done
);

    state_e      state_q, state_d;
    logic [31:0] ecx_q, ecx_d, esi_q, esi_d, edi_q, edi_d;
    logic        df_q, df_d, op_q, op_d;
    logic [1:0]  rep_q, rep_d, size_q, size_d;
    logic        rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [31:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic        latch_q, latch_d, ldf_q, ldf_d, done_q, done_d, busy_q, busy_d;
    logic [31:0] esi_nxt_s, edi_nxt_s, ecx_nxt_s;
    logic        upd_fin_s;

    alu1_str_ptr_upd u_ptr_upd (
        .esi_i     (esi_q),
        .edi_i     (edi_q),
        .ecx_i     (ecx_q),
        .df_i      (df_q),
        .op_size_i (size_q),
        .cnt_en_i  (rep_q != REP_NONE),
        .esi_o     (esi_nxt_s),
        .edi_o     (edi_nxt_s),
        .ecx_o     (ecx_nxt_s)
    );

    assign upd_fin_s = (rep_q == REP_NONE) || (ecx_nxt_s == 32'd0) ||
                       ((op_q == OP_CMPS) && (rep_q == REP_E)  && !cmps_zf) ||
                       ((op_q == OP_CMPS) && (rep_q == REP_NE) &&  cmps_zf);

    // Next-state and next-output computation
    always_comb begin
        state_d   = state_q;
        ecx_d     = ecx_q;
        esi_d     = esi_q;
        edi_d     = edi_q;
        df_d      = df_q;
        op_d      = op_q;
        rep_d     = rep_q;
        size_d    = size_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        latch_d   = 1'b0;
        ldf_d     = 1'b0;
        done_d    = 1'b0;
        if (stall) begin
            // Pending pulses are held so they surface in the first unstalled cycle.
            latch_d = latch_q;
            ldf_d   = ldf_q;
            done_d  = done_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ecx_d   = ecx_in;
                        esi_d   = esi_in;
                        edi_d   = edi_in;
                        df_d    = df_val;
                        op_d    = str_op;
                        rep_d   = norm_rep(rep_mode);
                        size_d  = norm_size(op_size);
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CHK: begin
                    if ((rep_q != REP_NONE) && (ecx_q == 32'd0)) begin
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = esi_q;
                        state_d   = ST_RD_SRC;
                    end
                end
                ST_RD_SRC: begin
                    if (mem_rd_ack) begin
                        latch_d = 1'b1;
                        if (op_q == OP_CMPS) begin
                            rd_addr_d = edi_q;
                            state_d   = ST_RD_DST;
                        end else begin
                            rd_req_d  = 1'b0;
                            wr_req_d  = 1'b1;
                            wr_addr_d = edi_q;
                            state_d   = ST_WR_DST;
                        end
                    end else begin
                        state_d = ST_RD_SRC;
                    end
                end
                ST_RD_DST: begin
                    if (mem_rd_ack) begin
                        ldf_d    = 1'b1;
                        rd_req_d = 1'b0;
                        state_d  = ST_UPD;
                    end else begin
                        state_d = ST_RD_DST;
                    end
                end
                ST_WR_DST: begin
                    if (mem_wr_ack) begin
                        wr_req_d = 1'b0;
                        state_d  = ST_UPD;
                    end else begin
                        state_d = ST_WR_DST;
                    end
                end
                ST_UPD: begin
                    esi_d = esi_nxt_s;
                    edi_d = edi_nxt_s;
                    ecx_d = ecx_nxt_s;
                    if (upd_fin_s) begin
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = esi_nxt_s;
                        state_d   = ST_RD_SRC;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ecx_q     <= 32'd0;
            esi_q     <= 32'd0;
            edi_q     <= 32'd0;
            df_q      <= 1'b0;
            op_q      <= 1'b0;
            rep_q     <= 2'b00;
            size_q    <= 2'b00;
            rd_req_q  <= 1'b0;
            rd_addr_q <= 32'd0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= 32'd0;
            latch_q   <= 1'b0;
            ldf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ecx_q     <= ecx_d;
            esi_q     <= esi_d;
            edi_q     <= edi_d;
            df_q      <= df_d;
            op_q      <= op_d;
            rep_q     <= rep_d;
            size_q    <= size_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            latch_q   <= latch_d;
            ldf_q     <= ldf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign mem_rd_req  = rd_req_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_req  = wr_req_q;
    assign mem_wr_addr = wr_addr_q;
    assign latch_en    = latch_q & ~stall;
    assign ld_flags    = ldf_q & ~stall;
    assign done        = done_q & ~stall;
    assign ecx_out     = ecx_q;
    assign esi_out     = esi_q;
    assign edi_out     = edi_q;

endmodule

// File: doc/alu1_str_seq.md
ALU1_STR_SEQ -- requirements
Module: alu1_str_seq

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width and meaning:
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: reset, synchronous and active-high.
- start, in, 1: one-cycle pulse that launches a string instruction; ignored while busy=1.
- str_op, in, 1: 0=MOVS, 1=CMPS.
- rep_mode, in, 2: 00=none, 01=REP/REPE, 10=REPNE; 11 is treated as 00.
- op_size, in, 2: 00=byte, 01=word, 10=dword; 11 is treated as 00.
- df_val, in, 1: direction flag, sampled at start.
- ecx_in, in, 32: count register.
- esi_in, in, 32: source pointer.
- edi_in, in, 32: destination pointer.
- mem_rd_ack, in, 1: read data is valid on mem_out this cycle.
- mem_wr_ack, in, 1: write has completed.
- cmps_zf, in, 1: ZF bit of the CMPS flag result from ALU1.
- stall, in, 1: freezes the FSM and all outputs.
- busy, out, 1: the sequence is active.
- mem_rd_req, out, 1: read request; held until acknowledged.
- mem_rd_addr, out, 32: read address.
- mem_wr_req, out, 1: write request; MOVS only.
- mem_wr_addr, out, 32: write address.
- latch_en, out, 1: capture mem_out into mem_out_latched.
- ld_flags, out, 1: load the CMPS flags into EFLAGS.
- ecx_out, out, 32: working count.
- esi_out, out, 32: working source pointer.
- edi_out, out, 32: working destination pointer.
- done, out, 1: one-cycle completion pulse.

Function
REQ-002 FSM states SHALL be IDLE, CHK, RD_SRC, RD_DST, WR_DST, UPD, FIN.
REQ-003 IDLE: when start=1, the block SHALL latch ecx_in, esi_in, edi_in, df_val, str_op, rep_mode and op_size into working registers, then go to CHK.
REQ-004 CHK: when rep_mode≠00 and the working ECX=0, the block SHALL go to FIN with no memory access; otherwise it SHALL go to RD_SRC.
REQ-005 RD_SRC: the block SHALL assert mem_rd_req with mem_rd_addr=ESI. On mem_rd_ack it SHALL pulse latch_en, then go to RD_DST for CMPS or WR_DST for MOVS.
REQ-006 RD_DST (CMPS only): the block SHALL assert mem_rd_req with mem_rd_addr=EDI. On mem_rd_ack it SHALL pulse ld_flags and go to UPD.
REQ-007 WR_DST (MOVS only): the block SHALL assert mem_wr_req with mem_wr_addr=EDI. On mem_wr_ack it SHALL go to UPD.
REQ-008 UPD: the block SHALL update the pointers as ESI±step and EDI±step, with step=1/2/4 by op_size, subtract when DF=1 and add when DF=0, modulo 2^32. When rep_mode≠00 it SHALL also set ECX=ECX−1.
REQ-009 UPD exit: the block SHALL go to FIN if any of the following holds, otherwise to RD_SRC:
- rep_mode=00;
- the new ECX=0;
- CMPS with REPE and cmps_zf=0;
- CMPS with REPNE and cmps_zf=1.
REQ-010 cmps_zf SHALL be sampled in UPD, one cycle after ld_flags.
REQ-011 FIN: the block SHALL pulse done for one cycle, drop busy and return to IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 Request outputs SHALL be registered and held stable until acknowledged; an ack arriving in a state that does not expect it SHALL be ignored.
REQ-014 While stall=1, state, working registers and request levels SHALL hold, and latch_en, ld_flags and done SHALL be 0; a pulse that would have fired SHALL fire in the first unstalled cycle.
REQ-015 Pointer updates SHALL wrap at 32 bits (0x0000_0000−1=0xFFFF_FFFF), and ECX SHALL never be decremented below 0.
REQ-016 Latency: a single non-REP CMPS with ack on the first request cycle SHALL take 5 cycles from start to done.

Reset
REQ-017 When rst=1 on a clock edge, the FSM SHALL go to IDLE and every output and working register SHALL become 0, including during an outstanding request; a pending ack in the following cycle SHALL be ignored.
REQ-018 rst SHALL have priority over start and stall.

Structure
REQ-019 The state enum, the str_op/rep_mode encodings and the op_size-to-step mapping SHALL live in shared package alu1_pkg.
REQ-020 The pointer/count stepping (REQ-008, REQ-015) SHALL be one sub-module, alu1_str_ptr_upd, that is purely combinational.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Non-REP MOVS: byte, DF=0, ESI=0x100, EDI=0x200 -> one read at 0x100 and one write at 0x200; esi_out=0x101, edi_out=0x201; done.
- REPE CMPS: dword, ECX=4, DF=1, ESI=0x10; the 2nd compare gives cmps_zf=0 -> exactly 2 iterations; ecx_out=2; esi_out=0x8; done.
- REP with ECX=0: start -> no mem_rd_req ever; done 2 cycles after start; all pointers unchanged.
- Pointer wrap: word, DF=1, ESI=0x0 -> esi_out=0xFFFF_FFFE.
- Stall and delayed ack: stall held 3 cycles in RD_SRC and ack delayed 2 cycles -> mem_rd_req stays high; latch_en fires exactly once, after the ack.
- Reset mid-operation: rst asserted in WR_DST -> busy=0 and mem_wr_req=0 next cycle; a following ack is ignored; no done pulse.
